// File: rtl/branch_pc_unit.sv
// Fetch-side PC register: applies stalls, branch/jump/jr redirects and branch-likely annulment.
// Halts fetch when the selected target is illegal, and counts resolved and taken branches.
module branch_pc_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter logic [31:0] PC_MIN  = 32'h0000_3000,
    parameter logic [31:0] PC_MAX  = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_d,
    input  logic        likely_d,
    input  logic        cmp_out,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16_d,
    input  logic        j_d,
    input  logic [25:0] j_index_d,
    input  logic        jr_d,
    input  logic [31:0] rs_d,
    output logic [31:0] pc_f,
    output logic        flush_f,
    output logic        halted,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned SEXT_W = XLEN - IMM_W - 2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_f_q, pc_f_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   br_cnt_q, br_cnt_d;
    logic [XLEN-1:0]   taken_cnt_q, taken_cnt_d;

    logic              adv;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   j_target;
    logic [XLEN-1:0]   pc_sel;
    logic              cond_br;
    logic              fault;

    // Target arithmetic is independent of state; priority is resolved below.
    assign br_target = pc_d + XLEN'(4) + {{SEXT_W{imm16_d[IMM_W-1]}}, imm16_d, 2'b00};
    assign j_target  = {pc_d[31:28], j_index_d, 2'b00};

    // Next-state, next-PC and counter logic.
    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        halted_d    = halted_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        flush_f     = 1'b0;
        fault       = 1'b0;
        cond_br     = 1'b0;
        pc_sel      = pc_f_q + XLEN'(4);
        adv         = reset_n && (state_q == ST_RUN) && !stall;

        if (jr_d) begin
            pc_sel = rs_d;
        end else if (j_d) begin
            pc_sel = j_target;
        end else if (br_d && cmp_out) begin
            pc_sel = br_target;
        end

        case (state_q)
            ST_RUN: begin
                if (adv) begin
                    cond_br = br_d && !jr_d && !j_d;
                    fault   = (pc_sel[1:0] != 2'b00) || (pc_sel < PC_MIN) || (pc_sel > PC_MAX);
                    flush_f = cond_br && likely_d && !cmp_out;
                    if (fault) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_f_d = pc_sel;
                        if (cond_br) begin
                            if (br_cnt_q != '1) begin
                                br_cnt_d = br_cnt_q + XLEN'(1);
                            end
                            if (cmp_out && (taken_cnt_q != '1)) begin
                                taken_cnt_d = taken_cnt_q + XLEN'(1);
                            end
                        end
                    end
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Synchronous active-low reset dominates every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            pc_f_q      <= PC_INIT;
            halted_q    <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            halted_q    <= halted_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc_f      = pc_f_q;
    assign halted    = halted_q;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule
